// File: rtl/store_buffer.sv
// Posted-write store buffer between the core data-RAM port and data memory.
// Stores are queued and drained in order whenever no load needs the memory
// port. Loads read memory combinationally, and any pending store bytes to the
// same word are merged over the memory data.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ram_ce_i,
    input  logic          ram_we_i,
    input  logic [AW-1:0] ram_addr_i,
    input  logic [DW-1:0] ram_data_i,
    input  logic [3:0]    ram_sel_i,
    output logic [DW-1:0] ram_data_o,
    output logic          stall_req_o,
    output logic          empty_o,
    output logic          mem_ce_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_data_o,
    output logic [3:0]    mem_sel_o,
    input  logic [DW-1:0] mem_data_i
);

    localparam int PW = $clog2(DEPTH);

    logic [AW-1:0]    entry_addr [DEPTH];
    logic [DW-1:0]    entry_data [DEPTH];
    logic [3:0]       entry_sel  [DEPTH];
    logic [DEPTH-1:0] entry_valid;

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;

    logic full;
    logic is_load;
    logic load_go;
    logic drain;
    logic enq;

    // Arbitration: a full buffer always drains; otherwise a load takes the
    // port and the drain waits; otherwise any pending store drains.
    always_comb begin
        full        = (count == (PW+1)'(DEPTH));
        is_load     = ram_ce_i & ~ram_we_i;
        load_go     = is_load & ~full;
        drain       = full | (~is_load & (count != '0));
        enq         = ram_ce_i & ram_we_i & ~full;
        stall_req_o = ram_ce_i & full;
        empty_o     = (count == '0);
    end

    // Drive the memory port from either the draining head entry or the load.
    always_comb begin
        mem_ce_o   = 1'b0;
        mem_we_o   = 1'b0;
        mem_addr_o = '0;
        mem_data_o = '0;
        mem_sel_o  = '0;
        if (drain) begin
            mem_ce_o   = 1'b1;
            mem_we_o   = 1'b1;
            mem_addr_o = entry_addr[rd_ptr];
            mem_data_o = entry_data[rd_ptr];
            mem_sel_o  = entry_sel[rd_ptr];
        end else if (load_go) begin
            mem_ce_o   = 1'b1;
            mem_addr_o = ram_addr_i;
        end
    end

    // Byte-wise forwarding: walk entries oldest to youngest so the youngest
    // matching store of each lane ends up on top of the memory data.
    always_comb begin
        logic [DW-1:0] merged;
        logic [PW-1:0] idx;
        merged = mem_data_i;
        idx    = rd_ptr;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr + PW'(k);
            if (entry_valid[idx] && (entry_addr[idx][AW-1:2] == ram_addr_i[AW-1:2])) begin
                for (int b = 0; b < 4; b++) begin
                    if (entry_sel[idx][b]) begin
                        merged[8*b +: 8] = entry_data[idx][8*b +: 8];
                    end
                end
            end
        end
        ram_data_o = load_go ? merged : '0;
    end

    // FIFO storage, pointers and occupancy; reset throws away pending stores.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            entry_valid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entry_addr[i] <= '0;
                entry_data[i] <= '0;
                entry_sel[i]  <= '0;
            end
        end else begin
            if (drain) begin
                entry_valid[rd_ptr] <= 1'b0;
                rd_ptr              <= rd_ptr + 1'b1;
            end
            if (enq) begin
                entry_addr[wr_ptr]  <= ram_addr_i;
                entry_data[wr_ptr]  <= ram_data_i;
                entry_sel[wr_ptr]   <= ram_sel_i;
                entry_valid[wr_ptr] <= 1'b1;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            case ({enq, drain})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: a queue-based model of pending stores
// plus a word-array memory model predict every output each cycle.
module tb_store_buffer;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst;
    logic        ram_ce;
    logic        ram_we;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [3:0]  ram_sel;
    logic [31:0] ram_rdata;
    logic        stall;
    logic        empty;
    logic        mem_ce;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_sel;
    logic [31:0] mem_rdata;

    store_buffer #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .ram_ce_i    (ram_ce),
        .ram_we_i    (ram_we),
        .ram_addr_i  (ram_addr),
        .ram_data_i  (ram_wdata),
        .ram_sel_i   (ram_sel),
        .ram_data_o  (ram_rdata),
        .stall_req_o (stall),
        .empty_o     (empty),
        .mem_ce_o    (mem_ce),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_data_o  (mem_wdata),
        .mem_sel_o   (mem_sel),
        .mem_data_i  (mem_rdata)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  sel;
    } ent_t;

    ent_t        q[$];
    logic [31:0] dmem    [256];
    logic [31:0] ref_mem [256];

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] s_rdata;
    logic        s_we;
    logic [31:0] s_maddr;
    logic [31:0] s_mdata;
    logic        s_empty;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory behind the buffer: combinational read, byte-enabled write.
    assign mem_rdata = dmem[mem_addr[9:2]];

    // Memory write port of the simulated data RAM.
    always @(posedge clk) begin
        if (mem_ce && mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_sel[b]) dmem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] forward(input logic [31:0] addr);
        logic [31:0] w;
        w = ref_mem[addr[9:2]];
        foreach (q[i]) begin
            if (q[i].addr[31:2] == addr[31:2]) begin
                for (int b = 0; b < 4; b++) begin
                    if (q[i].sel[b]) w[8*b +: 8] = q[i].data[8*b +: 8];
                end
            end
        end
        return w;
    endfunction

    // One core cycle: drive inputs, predict and compare outputs on the falling
    // edge, then advance the model across the rising edge.
    task automatic applyStimulus(input logic ce, input logic we, input logic [31:0] addr,
                                 input logic [31:0] data, input logic [3:0] sel);
        logic is_full, is_empty, exp_drain, exp_load, exp_enq;
        ent_t h;
        ram_ce    = ce;
        ram_we    = we;
        ram_addr  = addr;
        ram_wdata = data;
        ram_sel   = sel;
        @(negedge clk);
        is_full   = (q.size() == DEPTH);
        is_empty  = (q.size() == 0);
        exp_load  = ce && !we && !is_full;
        exp_drain = is_full || (!(ce && !we) && !is_empty);
        exp_enq   = ce && we && !is_full;
        h         = is_empty ? '0 : q[0];
        check("stall", 32'(stall), 32'(ce && is_full));
        check("empty", 32'(empty), 32'(is_empty));
        check("mem_ce", 32'(mem_ce), 32'(exp_drain || exp_load));
        check("mem_we", 32'(mem_we), 32'(exp_drain));
        if (exp_drain) begin
            check("drain_addr", mem_addr, h.addr);
            check("drain_data", mem_wdata, h.data);
            check("drain_sel", 32'(mem_sel), 32'(h.sel));
        end else if (exp_load) begin
            check("load_addr", mem_addr, addr);
        end else begin
            check("idle_addr", mem_addr, 32'h0);
            check("idle_data", mem_wdata, 32'h0);
            check("idle_sel", 32'(mem_sel), 32'h0);
        end
        if (exp_load) check("load_data", ram_rdata, forward(addr));
        else if (!(ce && !we)) check("noload_data", ram_rdata, 32'h0);
        s_rdata = ram_rdata;
        s_we    = mem_we;
        s_maddr = mem_addr;
        s_mdata = mem_wdata;
        s_empty = empty;
        @(posedge clk);
        if (exp_drain) begin
            for (int b = 0; b < 4; b++) begin
                if (h.sel[b]) ref_mem[h.addr[9:2]][8*b +: 8] = h.data[8*b +: 8];
            end
            void'(q.pop_front());
        end
        if (exp_enq) q.push_back('{addr: addr, data: data, sel: sel});
        #1;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        check(name, act, exp);
    endtask

    initial begin
        logic [31:0] v;
        logic [31:0] a;
        rst = 1'b1;
        ram_ce = 1'b0; ram_we = 1'b0; ram_addr = '0; ram_wdata = '0; ram_sel = '0;
        for (int i = 0; i < 256; i++) begin
            v = $urandom;
            dmem[i]    = v;
            ref_mem[i] = v;
        end
        dmem[8'h80]    = 32'hAABBCCDD;
        ref_mem[8'h80] = 32'hAABBCCDD;

        // Reset values.
        #12;
        checkOutput("rst_stall", 32'(stall), 32'h0);
        checkOutput("rst_empty", 32'(empty), 32'h1);
        checkOutput("rst_mem_ce", 32'(mem_ce), 32'h0);
        checkOutput("rst_mem_we", 32'(mem_we), 32'h0);
        checkOutput("rst_mem_addr", mem_addr, 32'h0);
        checkOutput("rst_mem_data", mem_wdata, 32'h0);
        checkOutput("rst_mem_sel", 32'(mem_sel), 32'h0);
        checkOutput("rst_ram_data", ram_rdata, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Single store followed by its drain.
        applyStimulus(1'b1, 1'b1, 32'h100, 32'h11223344, 4'hF);
        idle();
        checkOutput("t2_we", 32'(s_we), 32'h1);
        checkOutput("t2_addr", s_maddr, 32'h100);
        checkOutput("t2_data", s_mdata, 32'h11223344);
        idle();
        checkOutput("t2_empty", 32'(s_empty), 32'h1);

        // Byte-lane merge of a pending store over partially updated memory.
        applyStimulus(1'b1, 1'b1, 32'h200, 32'h000000EE, 4'b0001);
        applyStimulus(1'b1, 1'b1, 32'h200, 32'h00FF0000, 4'b0100);
        applyStimulus(1'b1, 1'b0, 32'h200, 32'h0, 4'h0);
        checkOutput("t4_merge", s_rdata, 32'hAAFFCCEE);
        idle(); idle();

        // Two stores to the same word: the newer data must be seen.
        applyStimulus(1'b1, 1'b1, 32'h300, 32'h1, 4'hF);
        applyStimulus(1'b1, 1'b1, 32'h300, 32'h2, 4'hF);
        applyStimulus(1'b1, 1'b0, 32'h300, 32'h0, 4'h0);
        checkOutput("t5_youngest", s_rdata, 32'h2);
        idle(); idle();

        // Back-to-back stores followed by a run of loads.
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, 32'h180 + 32'(4*i), $urandom, 4'hF);
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0, 32'h180 + 32'(4*i), 32'h0, 4'h0);
        idle(); idle();

        // Pointer wrap: stores interleaved with loads to unrelated words.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 1'b1, 32'h040 + 32'(4*i), $urandom, 4'($urandom_range(1, 15)));
            applyStimulus(1'b1, 1'b0, 32'h2C0 + 32'(4*i), 32'h0, 4'h0);
            if (i % 3 == 0) idle();
        end
        idle(); idle();

        // Randomized traffic over a small address window to exercise forwarding.
        for (int i = 0; i < 400; i++) begin
            a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 255)) << 2
                                            : 32'h300 + (32'($urandom_range(0, 3)) << 2);
            a = a | 32'($urandom_range(0, 3));
            applyStimulus($urandom_range(0, 3) != 0, 1'($urandom), a, $urandom, 4'($urandom));
        end
        idle(); idle();

        // Asynchronous reset while a store is draining: it must never land.
        applyStimulus(1'b1, 1'b1, 32'h3E0, 32'h5A5A5A5A, 4'hF);
        applyStimulus(1'b1, 1'b1, 32'h3E4, 32'hC3C3C3C3, 4'hF);
        ram_ce = 1'b0; ram_we = 1'b0;
        #2;
        checkOutput("t1_pre_we", 32'(mem_we), 32'h1);
        rst = 1'b1;
        #1;
        checkOutput("t1_empty", 32'(empty), 32'h1);
        checkOutput("t1_mem_ce", 32'(mem_ce), 32'h0);
        checkOutput("t1_stall", 32'(stall), 32'h0);
        q.delete();
        @(posedge clk); #3;
        rst = 1'b0;
        @(posedge clk); #1;
        idle(); idle();
        checkOutput("t1_not_written", dmem[8'hF9], ref_mem[8'hF9]);
        checkOutput("t1_first_landed", dmem[8'hF8], 32'h5A5A5A5A);

        // Final sweep: memory contents must agree with the model everywhere.
        for (int i = 0; i < 256; i++) begin
            if (dmem[i] !== ref_mem[i]) check("final_mem", dmem[i], ref_mem[i]);
        end
        check("final_empty", 32'(empty), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
